fw_update_sequencer: RTL and testbench

//   Avalon-MM master that runs a complete firmware-parameter commit on the fw_update register slave.
//   - Reads VERSION and checks the product ID.
//   - Unlocks with the password, writes the staged USER0..USER5 words and reads each back.
//   - Re-locks the slave and reports done/error.

---
 rtl/fw_update_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_fw_update_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fw_update_sequencer.sv
// Avalon-MM master that commits the staged USER words to the fw_update slave:
// version/product check, unlock, write, read-back verify, relock, done/error report.
module fw_update_sequencer #(
  parameter logic [7:0]  EXPECT_PRODUCT_ID = 8'd0,
  parameter bit          CHECK_PRODUCT     = 1'b1,
  parameter logic [31:0] LOCK_PWD          = 32'd12345,
  parameter logic [31:0] RELOCK_VALUE      = 32'd0,
  parameter logic [5:0]  WORD_MASK         = 6'h3F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        load_en,
  input  logic [2:0]  load_idx,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [2:0]  err_idx,
  output logic [23:0] fw_version,
  output logic [2:0]  avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write_n,
  output logic        avm_read_n,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_VER, S_UNLOCK, S_WR, S_RD, S_RELOCK, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] stage_q [6];
  logic [31:0] stage_d [6];
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [2:0]  err_idx_q, err_idx_d;
  logic [23:0] fw_version_q, fw_version_d;
  logic [2:0]  avm_address_q, avm_address_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic        avm_write_n_q, avm_write_n_d;
  logic        avm_read_n_q, avm_read_n_d;

  logic        start_acc;
  logic [3:0]  sel;
  logic [3:0]  first_sel;

  // Lowest enabled USER index at or above 'from'; bit 3 flags that one exists.
  function automatic logic [3:0] next_sel(input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 5; i >= 0; i--) begin
      if (WORD_MASK[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // busy stays high through the done cycle so a start coinciding with done is dropped.
  assign start_acc = start && (state_q == S_IDLE) && !busy_q;
  assign first_sel = next_sel(4'd0);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    stage_d         = stage_q;
    busy_d          = busy_q;
    done_d          = (state_q == S_FIN);
    error_d         = error_q;
    err_code_d      = err_code_q;
    err_idx_d       = err_idx_q;
    fw_version_d    = fw_version_q;
    avm_address_d   = 3'd0;
    avm_writedata_d = 32'd0;
    avm_write_n_d   = 1'b1;
    avm_read_n_d    = 1'b1;
    sel             = 4'b0000;

    if (done_q) busy_d = 1'b0;

    if (load_en && !busy_q && !start_acc && (load_idx < 3'd6)) begin
      stage_d[load_idx] = load_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d    = S_RD_VER;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          err_idx_d  = 3'd0;
        end
      end
      S_RD_VER: begin
        fw_version_d = avm_readdata[23:0];
        if (CHECK_PRODUCT && (avm_readdata[23:16] != EXPECT_PRODUCT_ID)) begin
          err_code_d = 2'd1;
          error_d    = 1'b1;
          state_d    = S_FIN;
        end else begin
          state_d = S_UNLOCK;
        end
      end
      S_UNLOCK: begin
        if (first_sel[3]) begin
          state_d = S_WR;
          idx_d   = first_sel[2:0];
        end else begin
          state_d = S_RELOCK;
        end
      end
      S_WR: begin
        sel = next_sel({1'b0, idx_q} + 4'd1);
        if (sel[3]) begin
          idx_d = sel[2:0];
        end else begin
          state_d = S_RD;
          idx_d   = first_sel[2:0];
        end
      end
      S_RD: begin
        sel = next_sel({1'b0, idx_q} + 4'd1);
        if (avm_readdata != stage_q[idx_q]) begin
          err_code_d = 2'd2;
          err_idx_d  = idx_q;
          error_d    = 1'b1;
          state_d    = S_RELOCK;
        end else if (sel[3]) begin
          idx_d = sel[2:0];
        end else begin
          state_d = S_RELOCK;
        end
      end
      S_RELOCK: state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Bus strobes follow the state being entered, so each access is registered
    // and occupies exactly the cycle its state is resident.
    case (state_d)
      S_RD_VER: begin
        avm_address_d = 3'd0;
        avm_read_n_d  = 1'b0;
      end
      S_UNLOCK: begin
        avm_address_d   = 3'd1;
        avm_writedata_d = LOCK_PWD;
        avm_write_n_d   = 1'b0;
      end
      S_WR: begin
        avm_address_d   = 3'd2 + idx_d;
        avm_writedata_d = stage_q[idx_d];
        avm_write_n_d   = 1'b0;
      end
      S_RD: begin
        avm_address_d = 3'd2 + idx_d;
        avm_read_n_d  = 1'b0;
      end
      S_RELOCK: begin
        avm_address_d   = 3'd1;
        avm_writedata_d = RELOCK_VALUE;
        avm_write_n_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      idx_q           <= 3'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      err_code_q      <= 2'd0;
      err_idx_q       <= 3'd0;
      fw_version_q    <= 24'd0;
      avm_address_q   <= 3'd0;
      avm_writedata_q <= 32'd0;
      avm_write_n_q   <= 1'b1;
      avm_read_n_q    <= 1'b1;
      for (int i = 0; i < 6; i++) stage_q[i] <= 32'd0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      err_code_q      <= err_code_d;
      err_idx_q       <= err_idx_d;
      fw_version_q    <= fw_version_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_write_n_q   <= avm_write_n_d;
      avm_read_n_q    <= avm_read_n_d;
      for (int i = 0; i < 6; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign err_idx       = err_idx_q;
  assign fw_version    = fw_version_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign avm_write_n   = avm_write_n_q;
  assign avm_read_n    = avm_read_n_q;

endmodule

// File: tb/tb_fw_update_sequencer.sv
// Bench for fw_update_sequencer: two instances (full mask with product check, sparse mask
// without it) against register-slave models and a transaction-list reference model.
module tb_fw_update_sequencer;

  localparam logic [5:0]  MASK0 = 6'h3F;
  localparam logic [5:0]  MASK1 = 6'b000101;
  localparam logic [7:0]  EID1  = 8'h5A;
  localparam logic [31:0] PWD1  = 32'hCAFE_0001;
  localparam logic [31:0] REL1  = 32'h0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, load_en;
  logic [2:0]  load_idx;
  logic [31:0] load_data;

  logic        busy0, done0, error0, wn0, rn0;
  logic [1:0]  ec0;
  logic [2:0]  ei0, addr0;
  logic [23:0] fv0;
  logic [31:0] wd0, rd0;
  logic        busy1, done1, error1, wn1, rn1;
  logic [1:0]  ec1;
  logic [2:0]  ei1, addr1;
  logic [23:0] fv1;
  logic [31:0] wd1, rd1;

  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];
  logic [31:0] ver0, ver1;
  logic [3:0]  cor0, cor1;
  logic [35:0] obs0 [$];
  logic [35:0] obs1 [$];
  logic [35:0] exp0 [$];
  logic [35:0] exp1 [$];
  logic [31:0] stage_m [6];
  logic [1:0]  ecode [2];
  logic [2:0]  eidx [2];
  int          ek [2];
  int          both_low = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  fw_update_sequencer u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .busy(busy0), .done(done0), .error(error0), .err_code(ec0),
    .err_idx(ei0), .fw_version(fv0), .avm_address(addr0), .avm_writedata(wd0),
    .avm_write_n(wn0), .avm_read_n(rn0), .avm_readdata(rd0)
  );

  fw_update_sequencer #(
    .EXPECT_PRODUCT_ID(EID1), .CHECK_PRODUCT(1'b0), .LOCK_PWD(PWD1),
    .RELOCK_VALUE(REL1), .WORD_MASK(MASK1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .busy(busy1), .done(done1), .error(error1), .err_code(ec1),
    .err_idx(ei1), .fw_version(fv1), .avm_address(addr1), .avm_writedata(wd1),
    .avm_write_n(wn1), .avm_read_n(rn1), .avm_readdata(rd1)
  );

  // Slave models: VERSION is fixed per run, a chosen USER word reads back with bit 0 flipped.
  assign rd0 = (addr0 == 3'd0) ? ver0 :
               (mem0[addr0] ^ (({1'b0, addr0} == cor0 + 4'd2) ? 32'd1 : 32'd0));
  assign rd1 = (addr1 == 3'd0) ? ver1 :
               (mem1[addr1] ^ (({1'b0, addr1} == cor1 + 4'd2) ? 32'd1 : 32'd0));

  always @(posedge clk) begin
    if (reset_n) begin
      if (!wn0) begin obs0.push_back({1'b1, addr0, wd0}); mem0[addr0] <= wd0; end
      if (!rn0) obs0.push_back({1'b0, addr0, rd0});
      if (!wn1) begin obs1.push_back({1'b1, addr1, wd1}); mem1[addr1] <= wd1; end
      if (!rn1) obs1.push_back({1'b0, addr1, rd1});
      if ((!wn0 && !rn0) || (!wn1 && !rn1)) both_low <= both_low + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: the commit as an ordered list of {write, address, data} bus accesses.
  task automatic model(input int w, input logic [5:0] mask, input bit chk,
                       input logic [7:0] eid, input logic [31:0] pwd, input logic [31:0] rel,
                       input logic [31:0] ver, input logic [3:0] cor);
    logic [35:0] q [$];
    logic [1:0]  code;
    logic [2:0]  idx;
    code = 2'd0;
    idx  = 3'd0;
    q.push_back({1'b0, 3'd0, ver});
    if (chk && (ver[23:16] != eid)) begin
      code = 2'd1;
    end else begin
      q.push_back({1'b1, 3'd1, pwd});
      for (int i = 0; i < 6; i++)
        if (mask[i]) q.push_back({1'b1, 3'(i + 2), stage_m[i]});
      for (int i = 0; i < 6 && code == 2'd0; i++) begin
        if (mask[i]) begin
          if (i == int'(cor)) begin
            q.push_back({1'b0, 3'(i + 2), stage_m[i] ^ 32'd1});
            code = 2'd2;
            idx  = 3'(i);
          end else begin
            q.push_back({1'b0, 3'(i + 2), stage_m[i]});
          end
        end
      end
      q.push_back({1'b1, 3'd1, rel});
    end
    if (w == 0) exp0 = q; else exp1 = q;
    ecode[w] = code;
    eidx[w]  = idx;
    ek[w]    = q.size() + 1;
  endtask

  task automatic load(input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (idx < 3'd6) stage_m[idx] = d;
  endtask

  task automatic run_trial(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [3:0] c0, input logic [3:0] c1, input bit rst_mid);
    int base0, base1, k0, k1, np0, np1, kmin, kmax;
    logic bz0, bz1;
    bit mid;
    ver0 = v0; ver1 = v1; cor0 = c0; cor1 = c1;
    model(0, MASK0, 1'b1, 8'h00, 32'd12345, 32'd0, v0, c0);
    model(1, MASK1, 1'b0, EID1, PWD1, REL1, v1, c1);
    base0 = obs0.size(); base1 = obs1.size();
    kmin = (ek[0] < ek[1]) ? ek[0] : ek[1];
    kmax = (ek[0] > ek[1]) ? ek[0] : ek[1];
    mid  = !rst_mid && (ek[0] >= 5) && (ek[1] >= 5);
    @(negedge clk);
    start = 1'b1;
    load_en = 1'($urandom_range(0, 1)); load_idx = 3'($urandom_range(0, 5)); load_data = $urandom;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    k0 = -1; k1 = -1; np0 = 0; np1 = 0; bz0 = 1'b1; bz1 = 1'b1;
    for (int k = 1; k <= kmax + 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      if (rst_mid && k == 7) begin
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_write_n0", wn0, 1); check_eq("rst_read_n0", rn0, 1);
        check_eq("rst_busy0", busy0, 0);  check_eq("rst_fw_version0", fv0, 0);
        check_eq("rst_write_n1", wn1, 1); check_eq("rst_read_n1", rn1, 1);
        check_eq("rst_busy1", busy1, 0);  check_eq("rst_address1", addr1, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) stage_m[i] = 32'd0;
        return;
      end
      if (k == 1) begin check_eq("busy_first0", busy0, 1); check_eq("busy_first1", busy1, 1); end
      if (k0 > 0 && k == k0 + 1) bz0 = busy0;
      if (k1 > 0 && k == k1 + 1) bz1 = busy1;
      if (done0) begin np0++; if (k0 < 0) k0 = k; end
      if (done1) begin np1++; if (k1 < 0) k1 = k; end
      if ((k == 5 && mid) || (!rst_mid && k == kmin)) start = 1'b1;
      if (k == 5 && mid) begin load_en = 1'b1; load_idx = 3'd0; load_data = $urandom; end
    end
    start = 1'b0; load_en = 1'b0;
    check_eq("done_cycle0", k0, ek[0]);   check_eq("done_cycle1", k1, ek[1]);
    check_eq("done_pulses0", np0, 1);     check_eq("done_pulses1", np1, 1);
    check_eq("busy_after0", bz0, 0);      check_eq("busy_after1", bz1, 0);
    check_eq("error0", error0, ecode[0] != 2'd0);
    check_eq("error1", error1, ecode[1] != 2'd0);
    check_eq("err_code0", ec0, ecode[0]); check_eq("err_code1", ec1, ecode[1]);
    check_eq("err_idx0", ei0, eidx[0]);   check_eq("err_idx1", ei1, eidx[1]);
    check_eq("fw_version0", fv0, v0[23:0]); check_eq("fw_version1", fv1, v1[23:0]);
    check_eq("txn_count0", obs0.size() - base0, exp0.size());
    check_eq("txn_count1", obs1.size() - base1, exp1.size());
    for (int i = 0; i < exp0.size() && base0 + i < obs0.size(); i++)
      check_eq("txn0", obs0[base0 + i], exp0[i]);
    for (int i = 0; i < exp1.size() && base1 + i < obs1.size(); i++)
      check_eq("txn1", obs1[base1 + i], exp1[i]);
  endtask

  function automatic logic [31:0] rand_ver(input bit allow_bad);
    logic [7:0] p;
    p = (allow_bad && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    return {8'($urandom), p, 16'($urandom)};
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; load_en = 1'b0; load_idx = 3'd0; load_data = 32'd0;
    ver0 = 32'd0; ver1 = 32'd0; cor0 = 4'd9; cor1 = 4'd9;
    for (int i = 0; i < 6; i++) stage_m[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy0", busy0, 0);       check_eq("reset_done0", done0, 0);
    check_eq("reset_error0", error0, 0);     check_eq("reset_err_code0", ec0, 0);
    check_eq("reset_err_idx0", ei0, 0);      check_eq("reset_fw_version0", fv0, 0);
    check_eq("reset_address0", addr0, 0);    check_eq("reset_writedata0", wd0, 0);
    check_eq("reset_write_n0", wn0, 1);      check_eq("reset_read_n0", rn0, 1);
    check_eq("reset_busy1", busy1, 0);       check_eq("reset_write_n1", wn1, 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) load(3'(i), 32'h11 * (i + 1));
    run_trial(32'h0000_0100, 32'h0033_0100, 4'd9, 4'd9, 1'b0);
    run_trial(32'h0005_0200, 32'h0012_0300, 4'd9, 4'd2, 1'b0);
    run_trial(32'h0000_0400, 32'h0000_0500, 4'd3, 4'd0, 1'b0);
    load(3'd6, 32'hDEAD_BEEF);
    load(3'd7, 32'hFEED_F00D);

    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) load(3'($urandom_range(0, 7)), $urandom);
      run_trial(rand_ver(1'b1), rand_ver(1'b1), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'b0);
    end

    run_trial(rand_ver(1'b0), rand_ver(1'b0), 4'd9, 4'd9, 1'b1);
    run_trial(rand_ver(1'b0), rand_ver(1'b0), 4'd9, 4'd9, 1'b0);
    load(3'd1, $urandom);
    run_trial(rand_ver(1'b1), rand_ver(1'b1), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'b0);

    check_eq("strobes_never_both_low", both_low, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
